mpadder_seq: RTL and testbench

- Multi-cycle, chunk-serial 1027-bit adder/subtractor for the Montgomery/RSA datapath.
- Responder side of the start/done handshake: accepts a one-cycle `start` with operands and returns `result` with a one-cycle `done` pulse.
- Trades latency for a short carry chain compared with the single-cycle adder.
- Drop-in for any controller that already drives start, subtract, in_a and in_b, and waits on done.

---
 rtl/mpadder_pkg.sv | 27 ++
 rtl/mpadder_chunk.sv | 22 ++
 rtl/mpadder_seq.sv | 103 ++++++++++
 tb/tb_mpadder_seq.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mpadder_pkg.sv
// Shared constants, state encoding and chunk helpers for the chunk-serial
// multi-precision adder/subtractor.
package mpadder_pkg;

    localparam int WIDTH     = 1027;
    localparam int CHUNK     = 128;
    localparam int NCHUNK    = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int EXT_W     = NCHUNK * CHUNK;
    localparam int PAD_W     = EXT_W - WIDTH;
    localparam int LAST_BITS = WIDTH - (NCHUNK - 1) * CHUNK;
    localparam int CNT_W     = $clog2(NCHUNK);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01
    } state_t;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t LAST_CNT = cnt_t'(NCHUNK - 1);

    // Valid-bit mask of a chunk: only the low LAST_BITS of the top chunk carry operand bits.
    function automatic logic [CHUNK-1:0] chunk_mask(input cnt_t idx);
        return (idx == LAST_CNT) ? ({CHUNK{1'b1}} >> (CHUNK - LAST_BITS)) : {CHUNK{1'b1}};
    endfunction

endpackage

// File: rtl/mpadder_chunk.sv
// Combinational CHUNK-bit adder with carry in/out; optionally inverts the
// valid bits of operand B so that subtraction becomes A + ~B + carry.
module mpadder_chunk
    import mpadder_pkg::*;
(
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic [CHUNK-1:0] i_mask,
    input  logic             i_invert,
    input  logic             i_carry,
    output logic [CHUNK-1:0] o_sum,
    output logic             o_carry
);

    logic [CHUNK-1:0] w_b;

    // Extension bits outside the mask must stay zero after inversion.
    assign w_b = i_invert ? (~i_b & i_mask) : i_b;

    assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, w_b} + {{CHUNK{1'b0}}, i_carry};

endmodule

// File: rtl/mpadder_seq.sv
// Chunk-serial WIDTH-bit adder/subtractor: one CHUNK-bit slice per cycle,
// start/done handshake, result held until the next completion.
module mpadder_seq
    import mpadder_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             subtract,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH:0]   result,
    output logic             done,
    output logic             busy
);

    state_t r_state;
    state_t w_state_next;

    cnt_t                            r_cnt;
    logic                            r_carry;
    logic                            r_sub;
    logic [EXT_W-1:0]                r_a;
    logic [EXT_W-1:0]                r_b;
    logic [(NCHUNK-1)*CHUNK-1:0]     r_shadow;

    logic             w_accept;
    logic             w_last;
    logic [CHUNK-1:0] w_sum;
    logic             w_cout;
    logic             w_final_carry;
    logic [WIDTH-1:0] w_assembled;

    assign w_accept = (r_state == IDLE) && start;
    assign w_last   = (r_state == RUN) && (r_cnt == LAST_CNT);
    assign busy     = (r_state == RUN);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start)  w_state_next = RUN;
            RUN:     if (w_last) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    mpadder_chunk u_chunk (
        .i_a      (r_a[r_cnt*CHUNK +: CHUNK]),
        .i_b      (r_b[r_cnt*CHUNK +: CHUNK]),
        .i_mask   (chunk_mask(r_cnt)),
        .i_invert (r_sub),
        .i_carry  (r_carry),
        .o_sum    (w_sum),
        .o_carry  (w_cout)
    );

    // Final carry sits at bit WIDTH, inside the top chunk unless WIDTH fills it exactly.
    generate
        if (LAST_BITS == CHUNK) begin : g_carry_full
            assign w_final_carry = w_cout;
        end else begin : g_carry_part
            assign w_final_carry = w_sum[LAST_BITS];
        end
    endgenerate

    assign w_assembled = {w_sum[LAST_BITS-1:0], r_shadow};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_sub    <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_shadow <= '0;
            result   <= '0;
            done     <= 1'b0;
        end else begin
            done <= w_last;
            if (w_accept) begin
                r_a     <= {{PAD_W{1'b0}}, in_a};
                r_b     <= {{PAD_W{1'b0}}, in_b};
                r_sub   <= subtract;
                r_carry <= subtract;
                r_cnt   <= '0;
            end else if (r_state == RUN) begin
                r_carry <= w_cout;
                r_cnt   <= r_cnt + cnt_t'(1);
                if (w_last) result <= {w_final_carry, w_assembled};
                else        r_shadow[r_cnt*CHUNK +: CHUNK] <= w_sum;
            end
        end
    end

endmodule

// File: tb/tb_mpadder_seq.sv
// Self-checking bench for mpadder_seq: directed cases from the test plan plus
// randomized operations compared against a plain-arithmetic reference model.
module tb_mpadder_seq;
    import mpadder_pkg::*;

    localparam int W = WIDTH;
    typedef logic [W:0]   wide_t;
    typedef logic [W-1:0] op_t;

    logic  clk = 1'b0;
    logic  rst;
    logic  start;
    logic  subtract;
    op_t   in_a;
    op_t   in_b;
    wide_t result;
    logic  done;
    logic  busy;

    int n_checks = 0;
    int n_errors = 0;

    mpadder_seq dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .subtract (subtract),
        .in_a     (in_a),
        .in_b     (in_b),
        .result   (result),
        .done     (done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input wide_t got, input wide_t exp);
        int diff_bit;
        diff_bit = -1;
        n_checks++;
        for (int i = W; i >= 0; i--)
            if (diff_bit < 0 && got[i] !== exp[i]) diff_bit = i;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed carry=%b low128=%h, expected carry=%b low128=%h, first differing bit %0d",
                   tag, got[W], got[127:0], exp[W], exp[127:0], diff_bit);
        end
    endtask

    // Reference: {carry, sum}; for subtract the carry is 1 exactly when a >= b.
    function automatic wide_t model(input op_t a, input op_t b, input logic sub);
        op_t diff;
        if (sub) begin
            diff = a - b;
            return {(a >= b), diff};
        end
        return {1'b0, a} + {1'b0, b};
    endfunction

    function automatic op_t rand_wide();
        op_t v;
        v = '0;
        for (int i = 0; i < (W + 31) / 32; i++) v = (v << 32) | op_t'($urandom());
        return v;
    endfunction

    // Starts one operation, scrambles the inputs while it runs, and returns in the done cycle.
    task automatic run_op(input op_t a, input op_t b, input logic sub, input string tag);
        wide_t exp;
        wide_t prev;
        int    lat;
        exp      = model(a, b, sub);
        prev     = result;
        start    = 1'b1;
        subtract = sub;
        in_a     = a;
        in_b     = b;
        tick();
        start = 1'b0;
        check({tag, "_done_low_after_start"}, wide_t'(done), wide_t'(0));
        lat = 0;
        while (!done && lat < 20) begin
            check({tag, "_busy"}, wide_t'(busy), wide_t'(1));
            check({tag, "_result_hold"}, result, prev);
            in_a     = rand_wide();
            in_b     = rand_wide();
            subtract = $urandom_range(0, 1);
            tick();
            lat++;
        end
        check({tag, "_latency"}, wide_t'(lat), wide_t'(NCHUNK));
        check({tag, "_result"}, result, exp);
        check({tag, "_busy_low_at_done"}, wide_t'(busy), wide_t'(0));
    endtask

    initial begin
        op_t   big;
        wide_t first_res;
        int    cyc;
        logic  saw_done;

        rst = 1'b1; start = 1'b1; subtract = 1'b1; in_a = '1; in_b = '1;
        tick();
        tick();
        check("reset_result", result, '0);
        check("reset_done", wide_t'(done), wide_t'(0));
        check("reset_busy", wide_t'(busy), wide_t'(0));
        rst = 1'b0; start = 1'b0;
        tick();
        check("idle_after_reset_busy", wide_t'(busy), wide_t'(0));

        run_op(op_t'(1), op_t'(1), 1'b0, "basic_add");
        tick();
        check("basic_add_done_one_cycle", wide_t'(done), wide_t'(0));
        check("basic_add_result_held", result, wide_t'(2));

        run_op('1, op_t'(1), 1'b0, "full_carry");
        tick();
        run_op(op_t'(7), op_t'(5), 1'b1, "sub_pos");
        tick();
        run_op(op_t'(5), op_t'(7), 1'b1, "sub_neg");
        tick();
        run_op(op_t'(1234), op_t'(1234), 1'b1, "sub_equal");
        tick();

        // Second start while busy must be ignored.
        start = 1'b1; subtract = 1'b0; in_a = op_t'(3); in_b = op_t'(4);
        tick();
        start = 1'b0;
        cyc = 0;
        repeat (3) begin tick(); cyc++; end
        start = 1'b1; in_a = op_t'(100); in_b = op_t'(100);
        tick();
        cyc++;
        start = 1'b0;
        while (!done && cyc < 20) begin tick(); cyc++; end
        check("busy_start_latency", wide_t'(cyc), wide_t'(NCHUNK));
        check("busy_start_result", result, wide_t'(7));
        saw_done = 1'b0;
        repeat (12) begin tick(); if (done) saw_done = 1'b1; end
        check("busy_start_no_second_done", wide_t'(saw_done), wide_t'(0));

        // Reset in the middle of an operation.
        start = 1'b1; subtract = 1'b0; in_a = rand_wide(); in_b = rand_wide();
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        check("midrst_result", result, '0);
        check("midrst_busy", wide_t'(busy), wide_t'(0));
        check("midrst_done", wide_t'(done), wide_t'(0));
        rst = 1'b0;
        tick();
        check("midrst_no_done", wide_t'(done), wide_t'(0));
        run_op(op_t'(10), op_t'(20), 1'b0, "after_rst");

        // Back-to-back: next start issued in the done cycle.
        tick();
        run_op(rand_wide(), rand_wide(), 1'b0, "b2b_first");
        first_res = result;
        big = op_t'(1) << (W - 1);
        run_op(big, big, 1'b0, "b2b_second");
        check("b2b_second_value", result, wide_t'(1) << W);
        check("b2b_first_differs_sanity", wide_t'(first_res == result), wide_t'(0));

        for (int i = 0; i < 24; i++) begin
            op_t  a;
            op_t  b;
            logic s;
            a = rand_wide();
            b = rand_wide();
            s = $urandom_range(0, 1);
            case ($urandom_range(0, 5))
                0: b = a;
                1: b = a + op_t'($urandom_range(0, 3));
                2: a = '1;
                default: ;
            endcase
            run_op(a, b, s, $sformatf("rand%0d", i));
            repeat ($urandom_range(0, 2)) begin
                tick();
                check($sformatf("rand%0d_done_pulse", i), wide_t'(done), wide_t'(0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
